// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: arms on a registered rising edge of ctrl_in[0] and writes qualified samples to a BRAM.
// Optional macro SNAP_CIRCULAR_EN adds the stop input and a circular capture mode selected by ctrl_in[3].
module snap_capture_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  input  logic [31:0]           ctrl_in,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_we,
  input  logic                  trig,
`ifdef SNAP_CIRCULAR_EN
  input  logic                  stop,
`endif
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_data,
  output logic                  bram_we,
  output logic [31:0]           status
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

`ifdef SNAP_CIRCULAR_EN
  localparam int CB = 4;
`else
  localparam int CB = 3;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;

  state_t                state;
  logic [CB-1:0]         ctrl_q;
  logic                  ctrl_loaded;
  logic                  arm_prev;
  logic [ADDR_WIDTH:0]   count;
  logic                  arm_edge;
  logic                  wr;
  logic                  stop_now;
  logic                  unused_ctrl;

  assign unused_ctrl = ^ctrl_in[31:CB];

`ifdef SNAP_CIRCULAR_EN
  logic                  circ_mode;
  logic                  wrapped;
  logic [ADDR_WIDTH-1:0] last_addr;
  assign stop_now = circ_mode & stop;
`else
  assign stop_now = 1'b0;
`endif

  // arm_prev resets high and only tracks once ctrl_q holds a real sample,
  // so an arm bit already high at reset release is not mistaken for an edge.
  assign arm_edge = ctrl_loaded & ctrl_q[0] & ~arm_prev;
  assign wr       = (state == S_CAPTURE) & (din_we | ctrl_q[2]) & ~stop_now;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state       <= S_IDLE;
      ctrl_q      <= '0;
      ctrl_loaded <= 1'b0;
      arm_prev    <= 1'b1;
      count       <= '0;
      bram_addr   <= '0;
      bram_data   <= '0;
      bram_we     <= 1'b0;
`ifdef SNAP_CIRCULAR_EN
      circ_mode   <= 1'b0;
      wrapped     <= 1'b0;
      last_addr   <= '0;
`endif
    end else begin
      ctrl_q      <= ctrl_in[CB-1:0];
      ctrl_loaded <= 1'b1;
      if (ctrl_loaded) arm_prev <= ctrl_q[0];

      // A sample qualified in the same cycle as a re-arm is still written at its old address.
      bram_we <= wr;
      if (wr) begin
        bram_addr <= count[ADDR_WIDTH-1:0];
        bram_data <= din;
      end

      if (arm_edge) begin
        count <= '0;
        state <= ctrl_q[1] ? S_ARMED : S_CAPTURE;
`ifdef SNAP_CIRCULAR_EN
        circ_mode <= ctrl_q[3];
        wrapped   <= 1'b0;
        last_addr <= '0;
`endif
      end else begin
        case (state)
          S_ARMED: begin
            if (trig) state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            if (stop_now) begin
              state <= S_DONE;
            end else if (wr) begin
`ifdef SNAP_CIRCULAR_EN
              if (circ_mode) begin
                count     <= {1'b0, count[ADDR_WIDTH-1:0] + ADDR_ONE};
                last_addr <= count[ADDR_WIDTH-1:0];
                if (count[ADDR_WIDTH-1:0] == LAST_ADDR) wrapped <= 1'b1;
              end else begin
                count <= count + CNT_ONE;
                if (count[ADDR_WIDTH-1:0] == LAST_ADDR) state <= S_DONE;
              end
`else
              count <= count + CNT_ONE;
              if (count[ADDR_WIDTH-1:0] == LAST_ADDR) state <= S_DONE;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status     = '0;
    status[31] = (state == S_DONE);
    status[30] = (state == S_ARMED) | (state == S_CAPTURE);
`ifdef SNAP_CIRCULAR_EN
    status[ADDR_WIDTH:0] = circ_mode ? {wrapped, last_addr} : count;
`else
    status[ADDR_WIDTH:0] = count;
`endif
  end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Bench for snap_capture_ctrl (ADDR_WIDTH=4): constant vector table, directed sequences, random run vs. flag-based model.
module tb_snap_capture_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          user_clk = 1'b0;
  logic          user_rst_n;
  logic [31:0]   ctrl_in;
  logic [DW-1:0] din;
  logic          din_we;
  logic          trig;
`ifdef SNAP_CIRCULAR_EN
  logic          stop;
`endif
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data;
  logic          bram_we;
  logic [31:0]   status;

  int n_vec  = 0;
  int n_err  = 0;
  int writes = 0;

  snap_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .user_clk  (user_clk),
    .user_rst_n(user_rst_n),
    .ctrl_in   (ctrl_in),
    .din       (din),
    .din_we    (din_we),
    .trig      (trig),
`ifdef SNAP_CIRCULAR_EN
    .stop      (stop),
`endif
    .bram_addr (bram_addr),
    .bram_data (bram_data),
    .bram_we   (bram_we),
    .status    (status)
  );

  always #5 user_clk = ~user_clk;

  // Reference model: "waiting for trigger", "capturing", "finished" flags plus a sample tally.
  logic [31:0] m_cq;
  bit          m_cq_valid, m_last_arm, m_wait, m_cap, m_fin;
  int          m_n;
  bit          e_we;
  logic [31:0] e_addr, e_data;

  function automatic void model_reset();
    m_cq = 0; m_cq_valid = 0; m_last_arm = 1;
    m_wait = 0; m_cap = 0; m_fin = 0; m_n = 0;
    e_we = 0; e_addr = 0; e_data = 0;
  endfunction

  function automatic void model_clock();
    bit edge_seen, take;
    edge_seen = m_cq_valid && m_cq[0] && !m_last_arm;
    take = m_cap && (din_we || m_cq[2]);
    e_we = take;
    if (take) begin
      e_addr = m_n;
      e_data = din;
      m_n++;
    end
    if (edge_seen) begin
      m_n = 0; m_fin = 0;
      m_wait = m_cq[1];
      m_cap  = !m_cq[1];
    end else if (m_wait && trig) begin
      m_wait = 0; m_cap = 1;
    end else if (m_cap && m_n == (1 << AW)) begin
      m_cap = 0; m_fin = 1;
    end
    if (m_cq_valid) m_last_arm = m_cq[0];
    m_cq = ctrl_in;
    m_cq_valid = 1;
  endfunction

  function automatic logic [31:0] exp_status();
    return (32'(m_fin) << 31) | (32'(m_wait || m_cap) << 30) | 32'(m_n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge user_clk);
    #1;
    chk("bram_we", 32'(bram_we), 32'(e_we));
    if (e_we) begin
      chk("bram_addr", 32'(bram_addr), e_addr);
      chk("bram_data", bram_data, e_data);
    end
    chk("status", status, exp_status());
    if (bram_we) writes++;
  endtask

  task automatic do_reset(input logic [31:0] c);
    user_rst_n = 1'b0;
    ctrl_in = c; din = '0; din_we = 1'b0; trig = 1'b0;
`ifdef SNAP_CIRCULAR_EN
    stop = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge user_clk);
    #1;
    chk("rst_we", 32'(bram_we), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_data", bram_data, 32'd0);
    chk("rst_status", status, 32'd0);
    @(negedge user_clk);
    user_rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] d;
    bit          we;
    bit          tg;
    bit          exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_status;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic [31:0] c, logic [31:0] d, bit w, bit t,
                              bit ew, logic [31:0] ea, logic [31:0] ed, logic [31:0] es);
    vec_t v;
    v.ctrl = c; v.d = d; v.we = w; v.tg = t;
    v.exp_we = ew; v.exp_addr = ea; v.exp_data = ed; v.exp_status = es;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // external trigger, gating, arm drop, re-arm with in-flight write, we_sel switch-over
    tbl[0]  = mk(32'h0, 32'h00, 1, 0, 0, 0, 0,     32'h0000_0000);
    tbl[1]  = mk(32'h3, 32'h00, 1, 0, 0, 0, 0,     32'h0000_0000);
    tbl[2]  = mk(32'h3, 32'h00, 1, 1, 0, 0, 0,     32'h4000_0000);
    tbl[3]  = mk(32'h3, 32'h00, 1, 0, 0, 0, 0,     32'h4000_0000);
    tbl[4]  = mk(32'h3, 32'h00, 1, 1, 0, 0, 0,     32'h4000_0000);
    tbl[5]  = mk(32'h3, 32'hA5, 1, 0, 1, 0, 32'hA5, 32'h4000_0001);
    tbl[6]  = mk(32'h3, 32'h00, 0, 0, 0, 0, 0,     32'h4000_0001);
    tbl[7]  = mk(32'h3, 32'h5A, 1, 0, 1, 1, 32'h5A, 32'h4000_0002);
    tbl[8]  = mk(32'h0, 32'h00, 0, 0, 0, 0, 0,     32'h4000_0002);
    tbl[9]  = mk(32'h0, 32'h07, 1, 0, 1, 2, 32'h07, 32'h4000_0003);
    tbl[10] = mk(32'h1, 32'h00, 0, 0, 0, 0, 0,     32'h4000_0003);
    tbl[11] = mk(32'h1, 32'h09, 1, 0, 1, 3, 32'h09, 32'h4000_0000);
    tbl[12] = mk(32'h1, 32'h10, 1, 0, 1, 0, 32'h10, 32'h4000_0001);
    tbl[13] = mk(32'h5, 32'h11, 0, 0, 0, 0, 0,     32'h4000_0001);
    tbl[14] = mk(32'h5, 32'h12, 0, 0, 1, 1, 32'h12, 32'h4000_0002);

    do_reset(32'h0);
    for (int i = 0; i < 15; i++) begin
      ctrl_in = tbl[i].ctrl; din = tbl[i].d; din_we = tbl[i].we; trig = tbl[i].tg;
      @(posedge user_clk);
      #1;
      chk($sformatf("tbl%0d_we", i), 32'(bram_we), 32'(tbl[i].exp_we));
      if (tbl[i].exp_we) begin
        chk($sformatf("tbl%0d_addr", i), 32'(bram_addr), tbl[i].exp_addr);
        chk($sformatf("tbl%0d_data", i), bram_data, tbl[i].exp_data);
      end
      chk($sformatf("tbl%0d_status", i), status, tbl[i].exp_status);
    end

    // immediate capture, every sample valid, data tracks address
    do_reset(32'h0);
    din_we = 1'b1;
    tick();
    ctrl_in = 32'h1; writes = 0;
    for (int c = 0; c < 24; c++) begin
      din = writes;
      tick();
      if (bram_we) chk("full_data", bram_data, 32'(writes - 1));
    end
    chk("full_nwrites", 32'(writes), 32'd16);
    chk("full_status", status, 32'h8000_0010);

    // alternating din_we
    do_reset(32'h0);
    tick();
    ctrl_in = 32'h1; writes = 0;
    for (int c = 0; c < 40; c++) begin
      din = $urandom; din_we = (c % 2 == 0);
      tick();
    end
    chk("alt_nwrites", 32'(writes), 32'd16);
    chk("alt_status", status, 32'h8000_0010);

    // external trigger after a long wait
    do_reset(32'h0);
    tick();
    ctrl_in = 32'h3; din_we = 1'b1;
    tick(); tick();
    writes = 0;
    for (int c = 0; c < 20; c++) begin
      din = $urandom;
      tick();
    end
    chk("trig_wait_nwrites", 32'(writes), 32'd0);
    chk("trig_wait_busy", 32'(status[30]), 32'd1);
    trig = 1'b1; tick();
    trig = 1'b0; din = 32'hCAFE; tick();
    chk("trig_first_we", 32'(bram_we), 32'd1);

    // re-arm after 7 writes
    do_reset(32'h0);
    tick();
    ctrl_in = 32'h1; din_we = 1'b1; writes = 0;
    for (int c = 0; c < 30 && writes < 7; c++) begin
      din = $urandom; tick();
    end
    chk("rearm_reached7", 32'(writes), 32'd7);
    ctrl_in = 32'h0; tick();
    ctrl_in = 32'h1;
    for (int c = 0; c < 30; c++) begin
      din = $urandom; tick();
    end
    chk("rearm_status", status, 32'h8000_0010);

    // reset mid-capture with arm held high
    do_reset(32'h0);
    tick();
    ctrl_in = 32'h1; din_we = 1'b1; writes = 0;
    for (int c = 0; c < 30 && writes < 5; c++) begin
      din = $urandom; tick();
    end
    chk("rstmid_reached5", 32'(writes), 32'd5);
    user_rst_n = 1'b0;
    #1;
    chk("rstmid_we", 32'(bram_we), 32'd0);
    chk("rstmid_status", status, 32'd0);
    model_reset();
    @(negedge user_clk);
    user_rst_n = 1'b1;
    writes = 0;
    repeat (25) tick();
    chk("rstmid_no_restart", 32'(writes), 32'd0);
    chk("rstmid_status_after", status, 32'd0);

`ifdef SNAP_CIRCULAR_EN
    // circular capture stopped after 20 writes
    do_reset(32'h0);
    din_we = 1'b1;
    @(posedge user_clk); #1;
    ctrl_in = 32'h9; writes = 0;
    for (int c = 0; c < 60 && writes < 20; c++) begin
      din = $urandom;
      @(posedge user_clk); #1;
      if (bram_we) writes++;
    end
    chk("circ_reached20", 32'(writes), 32'd20);
    stop = 1'b1;
    @(posedge user_clk); #1;
    chk("circ_stop_no_we", 32'(bram_we), 32'd0);
    stop = 1'b0;
    @(posedge user_clk); #1;
    chk("circ_status", status, 32'h8000_0013);
`endif

    // random run against the model; bit 3 kept low so circular mode stays off
    do_reset(32'h0);
    for (int c = 0; c < 4000; c++) begin
      din    = $urandom;
      din_we = ($urandom_range(0, 3) != 0);
      trig   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) ctrl_in = $urandom & 32'hFFFF_FFF7;
`ifdef SNAP_CIRCULAR_EN
      stop = $urandom_range(0, 1) == 1;
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
